pong_game_ctrl: RTL and testbench

Game sequencer for the pong display path. Consumes the raster counters and display-area flag from the sync generator. Once per frame it advances a ball and a player paddle through a four-state game FSM, and produces registered 1-bit R/G/B pixel data aligned with the registered sync outputs. It sits between the sync generator and the VGA colour pins.

---
 rtl/pong_pkg.sv | 16 +
 rtl/pong_game_ctrl_if.sv | 24 ++
 rtl/pong_ball_mover.sv | 75 +++++++
 rtl/pong_game_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types and screen constants for the pong game path.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_MISS  = 2'd3
  } state_e;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned BALL_X0  = 316;
  localparam int unsigned BALL_Y0  = 236;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Raster, button and pixel/score signals between the sync side and the game controller.
interface pong_game_ctrl_if;
  logic [9:0] CounterX;
  logic [8:0] CounterY;
  logic       inDisplayArea;
  logic       BTN_UP;
  logic       BTN_DOWN;
  logic       BTN_SERVE;
  logic       VGA_R;
  logic       VGA_G;
  logic       VGA_B;
  logic [7:0] SCORE;
  logic [1:0] STATE;

  modport master (
    output CounterX, CounterY, inDisplayArea, BTN_UP, BTN_DOWN, BTN_SERVE,
    input  VGA_R, VGA_G, VGA_B, SCORE, STATE
  );

  modport slave (
    input  CounterX, CounterY, inDisplayArea, BTN_UP, BTN_DOWN, BTN_SERVE,
    output VGA_R, VGA_G, VGA_B, SCORE, STATE
  );
endinterface

// File: rtl/pong_ball_mover.sv
// Combinational next-position logic for the ball: wall bounces, paddle hit, miss.
module pong_ball_mover
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SIZE  = 8,
  parameter int unsigned PADDLE_X   = 16,
  parameter int unsigned PADDLE_W   = 8,
  parameter int unsigned PADDLE_H   = 64,
  parameter int unsigned BALL_SPEED = 2
) (
  input  logic [9:0] i_bx,
  input  logic [8:0] i_by,
  input  logic       i_dxn,
  input  logic       i_dyn,
  input  logic [8:0] i_py,
  output logic [9:0] o_bx,
  output logic [8:0] o_by,
  output logic       o_dxn,
  output logic       o_dyn,
  output logic       o_hit,
  output logic       o_miss
);

  localparam logic signed [10:0] W_SPD  = 11'(BALL_SPEED);
  localparam logic signed [10:0] W_SZ   = 11'(BALL_SIZE);
  localparam logic signed [10:0] W_PH   = 11'(PADDLE_H);
  localparam logic signed [10:0] W_PEDG = 11'(PADDLE_X + PADDLE_W);
  localparam logic signed [10:0] W_H    = 11'(H_ACTIVE);
  localparam logic signed [10:0] W_V    = 11'(V_ACTIVE);

  logic signed [10:0] w_bx, w_by, w_py, w_nx, w_ny;
  logic               w_overlap;

  assign w_bx = signed'({1'b0, i_bx});
  assign w_by = signed'({2'b00, i_by});
  assign w_py = signed'({2'b00, i_py});
  assign w_nx = i_dxn ? (w_bx - W_SPD) : (w_bx + W_SPD);
  assign w_ny = i_dyn ? (w_by - W_SPD) : (w_by + W_SPD);

  // Ball rows [by, by+size) against paddle rows [py, py+h)
  assign w_overlap = (w_by < (w_py + W_PH)) && ((w_by + W_SZ) > w_py);

  // Horizontal rule: right wall, then paddle face, then left-edge miss
  always_comb begin
    o_bx   = w_nx[9:0];
    o_dxn  = i_dxn;
    o_hit  = 1'b0;
    o_miss = 1'b0;
    if (!i_dxn && ((w_nx + W_SZ) >= W_H)) begin
      o_bx  = 10'(H_ACTIVE - BALL_SIZE);
      o_dxn = 1'b1;
    end else if (i_dxn && (w_nx <= W_PEDG) && (w_bx >= W_PEDG) && w_overlap) begin
      o_bx  = 10'(PADDLE_X + PADDLE_W);
      o_dxn = 1'b0;
      o_hit = 1'b1;
    end else if (i_dxn && (w_nx <= 11'sd0)) begin
      o_bx   = '0;
      o_miss = 1'b1;
    end
  end

  // Vertical rule: top and bottom walls, independent of the horizontal rule
  always_comb begin
    o_by  = w_ny[8:0];
    o_dyn = i_dyn;
    if (i_dyn && (w_ny <= 11'sd0)) begin
      o_by  = '0;
      o_dyn = 1'b0;
    end else if (!i_dyn && ((w_ny + W_SZ) >= W_V)) begin
      o_by  = 9'(V_ACTIVE - BALL_SIZE);
      o_dyn = 1'b1;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame tick, paddle/ball state, game FSM and registered RGB.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned PADDLE_X     = 16,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned PADDLE_STEP  = 4,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned FRAME_LINE   = 480,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 30
) (
  input  logic             CLK,
  input  logic             RESET,
  pong_game_ctrl_if.slave  bus
);

  localparam int unsigned PY_MAX = V_ACTIVE - PADDLE_H;

  logic       r_tick;
  state_e     r_state;
  logic [7:0] r_cnt;
  logic [9:0] r_bx;
  logic [8:0] r_by;
  logic       r_dxn, r_dyn;
  logic [8:0] r_py;
  logic [7:0] r_score;
  logic       r_vga_r, r_vga_g, r_vga_b;

  logic [9:0]  w_bx_nxt;
  logic [8:0]  w_by_nxt;
  logic        w_dxn_nxt, w_dyn_nxt, w_hit, w_miss;
  logic [8:0]  w_py_nxt;
  logic [10:0] w_x;
  logic [9:0]  w_y;
  logic        w_in_ball, w_in_paddle, w_in_border;

  pong_ball_mover #(
    .BALL_SIZE (BALL_SIZE),
    .PADDLE_X  (PADDLE_X),
    .PADDLE_W  (PADDLE_W),
    .PADDLE_H  (PADDLE_H),
    .BALL_SPEED(BALL_SPEED)
  ) u_mover (
    .i_bx  (r_bx),
    .i_by  (r_by),
    .i_dxn (r_dxn),
    .i_dyn (r_dyn),
    .i_py  (r_py),
    .o_bx  (w_bx_nxt),
    .o_by  (w_by_nxt),
    .o_dxn (w_dxn_nxt),
    .o_dyn (w_dyn_nxt),
    .o_hit (w_hit),
    .o_miss(w_miss)
  );

  // One-cycle pulse on the first pixel of the frame line
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_tick <= 1'b0;
    else       r_tick <= (bus.CounterY == 9'(FRAME_LINE)) && (bus.CounterX == '0);
  end

  // Paddle step with saturation; both or neither button holds
  always_comb begin
    w_py_nxt = r_py;
    if (bus.BTN_UP && !bus.BTN_DOWN)
      w_py_nxt = (r_py >= 9'(PADDLE_STEP)) ? (r_py - 9'(PADDLE_STEP)) : '0;
    else if (bus.BTN_DOWN && !bus.BTN_UP)
      w_py_nxt = (r_py <= 9'(PY_MAX - PADDLE_STEP)) ? (r_py + 9'(PADDLE_STEP)) : 9'(PY_MAX);
  end

  // Game FSM, ball, paddle and score; everything advances only on the frame tick
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bx    <= 10'(BALL_X0);
      r_by    <= 9'(BALL_Y0);
      r_dxn   <= 1'b0;
      r_dyn   <= 1'b0;
      r_py    <= 9'(PY_MAX / 2);
      r_score <= '0;
    end else if (r_tick) begin
      r_py <= w_py_nxt;
      case (r_state)
        ST_IDLE: begin
          r_bx  <= 10'(BALL_X0);
          r_by  <= 9'(BALL_Y0);
          r_dxn <= 1'b0;
          r_dyn <= 1'b0;
          if (bus.BTN_SERVE) begin
            r_state <= ST_SERVE;
            r_cnt   <= 8'(SERVE_FRAMES - 1);
          end
        end
        ST_SERVE: begin
          if (r_cnt == '0) r_state <= ST_PLAY;
          else             r_cnt   <= r_cnt - 8'd1;
        end
        ST_PLAY: begin
          r_bx  <= w_bx_nxt;
          r_by  <= w_by_nxt;
          r_dxn <= w_dxn_nxt;
          r_dyn <= w_dyn_nxt;
          if (w_hit && (r_score != '1)) r_score <= r_score + 8'd1;
          if (w_miss) begin
            r_state <= ST_MISS;
            r_cnt   <= 8'(MISS_FRAMES - 1);
          end
        end
        ST_MISS: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_bx    <= 10'(BALL_X0);
            r_by    <= 9'(BALL_Y0);
            r_dxn   <= 1'b0;
            r_dyn   <= 1'b0;
            r_score <= '0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_x = {1'b0, bus.CounterX};
  assign w_y = {1'b0, bus.CounterY};

  assign w_in_ball = (w_x >= {1'b0, r_bx}) && (w_x < ({1'b0, r_bx} + 11'(BALL_SIZE))) &&
                     (w_y >= {1'b0, r_by}) && (w_y < ({1'b0, r_by} + 10'(BALL_SIZE)));
  assign w_in_paddle = (bus.CounterX >= 10'(PADDLE_X)) &&
                       (bus.CounterX < 10'(PADDLE_X + PADDLE_W)) &&
                       (w_y >= {1'b0, r_py}) && (w_y < ({1'b0, r_py} + 10'(PADDLE_H)));
  assign w_in_border = (bus.CounterY < 9'd4) || (bus.CounterY >= 9'(V_ACTIVE - 4)) ||
                       (bus.CounterX >= 10'(H_ACTIVE - 4));

  // Pixel colour, one cycle behind the raster counters
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_vga_r <= 1'b0;
      r_vga_g <= 1'b0;
      r_vga_b <= 1'b0;
    end else begin
      r_vga_r <= bus.inDisplayArea && w_in_ball && (r_state != ST_MISS);
      r_vga_g <= bus.inDisplayArea && w_in_paddle;
      r_vga_b <= bus.inDisplayArea && w_in_border;
    end
  end

  assign bus.VGA_R = r_vga_r;
  assign bus.VGA_G = r_vga_g;
  assign bus.VGA_B = r_vga_b;
  assign bus.SCORE = r_score;
  assign bus.STATE = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: table vectors on the ball mover, then a scripted
// and randomized game run against an integer model of the game rules.
module tb_pong_game_ctrl;

  logic CLK;
  logic RESET;
  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .BALL_SIZE(8), .PADDLE_X(16), .PADDLE_W(8), .PADDLE_H(64), .PADDLE_STEP(4),
    .BALL_SPEED(2), .FRAME_LINE(480), .SERVE_FRAMES(60), .MISS_FRAMES(30)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  logic [9:0] mv_bx;
  logic [8:0] mv_by;
  logic       mv_dxn, mv_dyn;
  logic [8:0] mv_py;
  logic [9:0] mo_bx;
  logic [8:0] mo_by;
  logic       mo_dxn, mo_dyn, mo_hit, mo_miss;

  pong_ball_mover #(
    .BALL_SIZE(8), .PADDLE_X(16), .PADDLE_W(8), .PADDLE_H(64), .BALL_SPEED(2)
  ) u_mv (
    .i_bx(mv_bx), .i_by(mv_by), .i_dxn(mv_dxn), .i_dyn(mv_dyn), .i_py(mv_py),
    .o_bx(mo_bx), .o_by(mo_by), .o_dxn(mo_dxn), .o_dyn(mo_dyn),
    .o_hit(mo_hit), .o_miss(mo_miss)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int bx, by, dxn, dyn, py;
    int ebx, eby, edxn, edyn, ehit, emiss;
  } mvec_t;
  mvec_t tbl[$];

  // Game model: velocities as signed integers, states as plain numbers
  int m_st, m_cnt, m_bx, m_by, m_vx, m_vy, m_py, m_score;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic addv(input int bx, by, dxn, dyn, py, ebx, eby, edxn, edyn, ehit, emiss);
    mvec_t v;
    v.bx = bx; v.by = by; v.dxn = dxn; v.dyn = dyn; v.py = py;
    v.ebx = ebx; v.eby = eby; v.edxn = edxn; v.edyn = edyn; v.ehit = ehit; v.emiss = emiss;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2; m_py = 208; m_score = 0;
  endtask

  task automatic model_tick(input bit up, input bit dn, input bit sv);
    int old_py, nx, ny;
    old_py = m_py;
    if (up && !dn)      m_py = (m_py >= 4) ? m_py - 4 : 0;
    else if (dn && !up) m_py = (m_py + 4 <= 416) ? m_py + 4 : 416;
    case (m_st)
      0: if (sv) begin m_st = 1; m_cnt = 59; end
      1: if (m_cnt == 0) m_st = 2; else m_cnt--;
      2: begin
        nx = m_bx + m_vx;
        ny = m_by + m_vy;
        if (m_vx > 0 && nx + 8 >= 640) begin
          m_bx = 632; m_vx = -2;
        end else if (m_vx < 0 && nx <= 24 && m_bx >= 24 &&
                     m_by < old_py + 64 && m_by + 8 > old_py) begin
          m_bx = 24; m_vx = 2;
          if (m_score < 255) m_score++;
        end else if (m_vx < 0 && nx <= 0) begin
          m_bx = 0; m_st = 3; m_cnt = 29;
        end else begin
          m_bx = nx;
        end
        if (m_vy < 0 && ny <= 0)             begin m_by = 0;   m_vy = 2;  end
        else if (m_vy > 0 && ny + 8 >= 480)  begin m_by = 472; m_vy = -2; end
        else                                 m_by = ny;
      end
      default: begin
        if (m_cnt == 0) begin
          m_st = 0; m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2; m_score = 0;
        end else m_cnt--;
      end
    endcase
  endtask

  function automatic int exp_rgb(input int x, input int y, input bit d);
    int r, g, b;
    r = (d && m_st != 3 && x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) ? 1 : 0;
    g = (d && x >= 16 && x < 24 && y >= m_py && y < m_py + 64) ? 1 : 0;
    b = (d && (y < 4 || y >= 476 || x >= 636)) ? 1 : 0;
    return r * 4 + g * 2 + b;
  endfunction

  function automatic int act_rgb();
    return int'({bus.VGA_R, bus.VGA_G, bus.VGA_B});
  endfunction

  task automatic check_game(input string tag);
    chk({tag, "_state"}, int'(bus.STATE), m_st);
    chk({tag, "_score"}, int'(bus.SCORE), m_score);
    chk({tag, "_py"}, int'(dut.r_py), m_py);
    if (m_st != 3) begin
      chk({tag, "_bx"}, int'(dut.r_bx), m_bx);
      chk({tag, "_by"}, int'(dut.r_by), m_by);
    end
  endtask

  // Two-cycle frame: tick raised at the first edge, state updates at the second
  task automatic do_tick(input bit up, input bit dn, input bit sv, input string tag);
    bus.BTN_UP = up; bus.BTN_DOWN = dn; bus.BTN_SERVE = sv;
    bus.CounterY = 9'd480; bus.CounterX = 10'd0; bus.inDisplayArea = 1'b0;
    @(posedge CLK); #1;
    bus.CounterX = 10'd5;
    @(posedge CLK); #1;
    model_tick(up, dn, sv);
    check_game(tag);
  endtask

  task automatic pix(input int x, input int y, input bit d, input string tag);
    if (y == 480 && x == 0) x = 1;
    bus.CounterX = 10'(x); bus.CounterY = 9'(y); bus.inDisplayArea = d;
    @(posedge CLK); #1;
    chk(tag, act_rgb(), exp_rgb(x, y, d));
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  initial begin
    bit up, dn, sv, reset_done;
    int x, y, k;

    RESET = 1'b1;
    bus.CounterX = '0; bus.CounterY = '0; bus.inDisplayArea = 1'b0;
    bus.BTN_UP = 1'b0; bus.BTN_DOWN = 1'b0; bus.BTN_SERVE = 1'b0;
    mv_bx = '0; mv_by = '0; mv_dxn = 1'b0; mv_dyn = 1'b0; mv_py = '0;

    // bx, by, dxn, dyn, py -> bx, by, dxn, dyn, hit, miss
    addv(316, 236, 0, 0, 208, 318, 238, 0, 0, 0, 0);
    addv(100, 471, 0, 0, 208, 102, 472, 0, 1, 0, 0);
    addv(100, 470, 0, 0,   0, 102, 472, 0, 1, 0, 0);
    addv(631, 100, 0, 1, 208, 632,  98, 1, 1, 0, 0);
    addv(629, 100, 0, 0, 208, 631, 102, 0, 0, 0, 0);
    addv( 25, 220, 1, 0, 200,  24, 222, 0, 0, 1, 0);
    addv( 25, 220, 1, 0, 300,  23, 222, 1, 0, 0, 0);
    addv(  1,  50, 1, 1, 300,   0,  48, 1, 1, 0, 1);
    addv(  2,  50, 1, 0, 300,   0,  52, 1, 0, 0, 1);
    addv(  3,  50, 1, 0, 300,   1,  52, 1, 0, 0, 0);
    addv(631,   2, 0, 1, 208, 632,   0, 1, 0, 0, 0);
    addv(100,   3, 0, 1, 208, 102,   1, 0, 1, 0, 0);
    addv( 25, 192, 1, 0, 200,  23, 194, 1, 0, 0, 0);
    addv( 25, 193, 1, 0, 200,  24, 195, 0, 0, 1, 0);
    addv( 25, 263, 1, 1, 200,  24, 261, 0, 1, 1, 0);
    addv( 25, 264, 1, 1, 200,  23, 262, 1, 1, 0, 0);
    addv( 24, 100, 1, 0,  80,  24, 102, 0, 0, 1, 0);
    addv( 23, 100, 1, 0,  80,  21, 102, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      mv_bx = 10'(tbl[i].bx); mv_by = 9'(tbl[i].by);
      mv_dxn = tbl[i].dxn[0]; mv_dyn = tbl[i].dyn[0]; mv_py = 9'(tbl[i].py);
      #1;
      chk($sformatf("mover%0d_bx", i), int'(mo_bx), tbl[i].ebx);
      chk($sformatf("mover%0d_by", i), int'(mo_by), tbl[i].eby);
      chk($sformatf("mover%0d_flags", i),
          int'({mo_dxn, mo_dyn, mo_hit, mo_miss}),
          tbl[i].edxn * 8 + tbl[i].edyn * 4 + tbl[i].ehit * 2 + tbl[i].emiss);
    end

    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_state", int'(bus.STATE), 0);
    chk("reset_score", int'(bus.SCORE), 0);
    chk("reset_rgb", act_rgb(), 0);
    check_game("reset");
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;

    pix(316, 236, 1'b1, "pix_ball_on");
    chk("pix_ball_r", int'(bus.VGA_R), 1);
    pix(316, 236, 1'b0, "pix_ball_blank");
    chk("pix_blank_r", int'(bus.VGA_R), 0);
    pix(323, 243, 1'b1, "pix_ball_corner");
    pix(324, 236, 1'b1, "pix_ball_right_edge");
    pix(20, 208, 1'b1, "pix_paddle_top");
    pix(639, 100, 1'b1, "pix_border_right");

    for (int i = 1; i <= 60; i++) begin
      do_tick(1'b1, 1'b0, 1'b0, "up");
      if (i == 52) chk("py_reaches_0", int'(dut.r_py), 0);
    end
    chk("py_stays_0", int'(dut.r_py), 0);
    repeat (3) do_tick(1'b0, 1'b1, 1'b0, "down");
    repeat (5) do_tick(1'b1, 1'b1, 1'b0, "both");
    chk("both_hold", int'(dut.r_py), 12);

    do_tick(1'b0, 1'b0, 1'b1, "serve");
    chk("serve_enter", int'(bus.STATE), 1);
    for (int i = 1; i <= 60; i++) do_tick(1'b0, 1'b0, 1'b1, "serving");
    chk("play_after_60", int'(bus.STATE), 2);
    do_tick(1'b0, 1'b0, 1'b0, "first_move");
    chk("first_move_bx", int'(dut.r_bx), 318);
    chk("first_move_by", int'(dut.r_by), 238);

    reset_done = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 3) != 0) begin
        up = (m_py + 32 > m_by + 6);
        dn = (m_py + 32 < m_by + 2);
      end else begin
        up = 1'($urandom_range(0, 1));
        dn = 1'($urandom_range(0, 1));
      end
      sv = ($urandom_range(0, 3) == 0);
      do_tick(up, dn, sv, "rand");
      for (int p = 0; p < 2; p++) begin
        k = $urandom_range(0, 2);
        if (k == 0) begin
          x = m_bx - 2 + $urandom_range(0, 11); y = m_by - 2 + $urandom_range(0, 11);
        end else if (k == 1) begin
          x = 12 + $urandom_range(0, 15); y = m_py - 2 + $urandom_range(0, 67);
        end else begin
          x = $urandom_range(0, 767); y = $urandom_range(0, 511);
        end
        pix(clampi(x, 0, 767), clampi(y, 0, 511), ($urandom_range(0, 7) != 0), "rand_pix");
      end
      if (!reset_done && m_st == 2 && (m_score >= 1 || t > 1200)) begin
        reset_done = 1'b1;
        bus.CounterX = 10'd320; bus.CounterY = 9'd240; bus.inDisplayArea = 1'b1;
        #2 RESET = 1'b1;
        #1;
        model_reset();
        chk("async_reset_state", int'(bus.STATE), 0);
        chk("async_reset_score", int'(bus.SCORE), 0);
        chk("async_reset_rgb", act_rgb(), 0);
        check_game("async_reset");
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
